// File: rtl/regfile_dec_pkg.sv
// Shared definitions for the register-file write-enable decoder.
// Contents:
//   aw_of()          - address width needed to index a register file of a given size
//   DEF_WIDTH/PORTS  - the default core configuration (32 registers, 2 write ports)
//   stage_default_t  - pipeline stage record for the default configuration
//   STAGE_BUBBLE     - all-zero stage record (an empty pipeline slot)
package regfile_dec_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PORTS = 2;

  // A one-register file would still need one address bit to keep port widths legal.
  function automatic int aw_of(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // The top rebuilds this record with its own parameter widths. This fixed-size
  // version describes the field layout for the default core.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] we_vec;
    logic [DEF_PORTS-1:0] port_won;
    logic                 collision;
  } stage_default_t;

  localparam stage_default_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/regfile_wr_decoder_pipe_onehot_decode.sv
// Combinational one-hot decoder for a single write port.
// Ports:
//   addr   in  AW     register index
//   en     in  1      port is allowed to write
//   onehot out WIDTH  bit addr set when en, otherwise all zero
module onehot_decode
  import regfile_dec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = aw_of(WIDTH)
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  // WIDTH is a power of two, so every address value selects a real bit.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_decoder_pipe.sv
// Pipelined write-enable decoder for the register file of the pipelined ARM core.
// Up to PORTS write addresses are decoded into one shared word-enable vector.
// Writes to the zero register are dropped, and when two ports hit the same
// register the highest-indexed port wins. The result goes through STAGES
// registers that the hazard unit can stall or flush.
// Ports:
//   clk              in   rising-edge clock
//   reset_n          in   synchronous active-low reset
//   stall            in   hold every stage
//   flush            in   load bubbles into every stage (beats stall)
//   en               in   PORTS       per-port write request
//   addr             in   PORTS*AW    packed addresses, port p at [p*AW +: AW]
//   clr_sticky       in   clear the latched collision flag
//   we_vec           out  WIDTH       registered word-enable vector
//   port_won         out  PORTS       registered, port p's write is in we_vec
//   valid_out        out  |we_vec
//   collision        out  registered pulse aligned with we_vec
//   collision_sticky out  latched collision flag
module regfile_wr_decoder_pipe
  import regfile_dec_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int PORTS        = 2,
  parameter int STAGES       = 1,
  parameter int HAS_ZERO_REG = 1,
  parameter int ZERO_IDX     = WIDTH - 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [PORTS-1:0]         en,
  input  logic [PORTS*aw_of(WIDTH)-1:0] addr,
  input  logic                     clr_sticky,
  output logic [WIDTH-1:0]         we_vec,
  output logic [PORTS-1:0]         port_won,
  output logic                     valid_out,
  output logic                     collision,
  output logic                     collision_sticky
);

  localparam int AW = aw_of(WIDTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  typedef struct packed {
    logic [WIDTH-1:0] we_vec;
    logic [PORTS-1:0] port_won;
    logic             collision;
  } stage_t;

  logic [AW-1:0]    port_addr   [PORTS];
  logic [WIDTH-1:0] port_onehot [PORTS];
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] won;
  logic [WIDTH-1:0] dec_we;
  logic             dec_collision;
  stage_t           dec;

  stage_t           pipe_d [STAGES];
  stage_t           pipe_q [STAGES];
  stage_t           last;
  logic             sticky;

  // A zero-register write is removed here, before arbitration, so it can never
  // take part in a collision.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign port_addr[p] = addr[p*AW +: AW];
    assign req[p] = en[p] && !((HAS_ZERO_REG != 0) && (port_addr[p] == ZERO_ADDR));

    onehot_decode #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_onehot (
      .addr   (port_addr[p]),
      .en     (won[p]),
      .onehot (port_onehot[p])
    );
  end

  // A port loses only to a higher-indexed requester on the same address, so
  // every live address keeps exactly one winner.
  always_comb begin
    won           = req;
    dec_collision = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = p + 1; q < PORTS; q++) begin
        if (req[p] && req[q] && (port_addr[p] == port_addr[q])) begin
          won[p]        = 1'b0;
          dec_collision = 1'b1;
        end
      end
    end
  end

  // Winners have distinct addresses, so OR-ing them builds a multi-write vector.
  always_comb begin
    dec_we = '0;
    for (int p = 0; p < PORTS; p++) begin
      dec_we = dec_we | port_onehot[p];
    end
  end

  assign dec = '{we_vec: dec_we, port_won: won, collision: dec_collision};

  // Stage s loads from stage s-1 (stage 0 loads from the decoder). Flush zeroes
  // every stage, even while stalled.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign pipe_d[s] = dec;
    end else begin : g_tail
      assign pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        pipe_q[s] <= '0;
      end else if (flush) begin
        pipe_q[s] <= '0;
      end else if (!stall) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  // The flag is set on the edge that loads a collision into the output stage,
  // so it rises together with the collision pulse. A set on the same edge as a
  // clear wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky <= 1'b0;
    end else if (!flush && !stall && pipe_d[STAGES-1].collision) begin
      sticky <= 1'b1;
    end else if (clr_sticky) begin
      sticky <= 1'b0;
    end
  end

  assign last             = pipe_q[STAGES-1];
  assign we_vec           = last.we_vec;
  assign port_won         = last.port_won;
  assign collision        = last.collision;
  assign valid_out        = |last.we_vec;
  assign collision_sticky = sticky;

endmodule

// File: tb/tb_regfile_wr_decoder_pipe.sv
// Self-checking bench for regfile_wr_decoder_pipe. Three copies of the design
// (STAGES = 1, 2, 3) share one stimulus stream. A behavioural model predicts
// every output on every cycle, and table vectors plus hand-written sequences
// pin down the specific corner cases.
module tb_regfile_wr_decoder_pipe;

  typedef struct packed {
    logic [31:0] we;
    logic [1:0]  won;
    logic        col;
  } rec_t;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] we;
    logic [1:0]  won;
    logic        col;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        clr_sticky;
  logic [1:0]  en;
  logic [9:0]  addr;

  logic [31:0] we_o  [3];
  logic [1:0]  won_o [3];
  logic        val_o [3];
  logic        col_o [3];
  logic        stk_o [3];

  int checks   = 0;
  int failures = 0;

  rec_t mp [3][3];
  logic msticky [3];

  always #5 clk = ~clk;

  regfile_wr_decoder_pipe #(.WIDTH(32), .PORTS(2), .STAGES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .en(en), .addr(addr),
    .clr_sticky(clr_sticky), .we_vec(we_o[0]), .port_won(won_o[0]), .valid_out(val_o[0]),
    .collision(col_o[0]), .collision_sticky(stk_o[0]));

  regfile_wr_decoder_pipe #(.WIDTH(32), .PORTS(2), .STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .en(en), .addr(addr),
    .clr_sticky(clr_sticky), .we_vec(we_o[1]), .port_won(won_o[1]), .valid_out(val_o[1]),
    .collision(col_o[1]), .collision_sticky(stk_o[1]));

  regfile_wr_decoder_pipe #(.WIDTH(32), .PORTS(2), .STAGES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .en(en), .addr(addr),
    .clr_sticky(clr_sticky), .we_vec(we_o[2]), .port_won(won_o[2]), .valid_out(val_o[2]),
    .collision(col_o[2]), .collision_sticky(stk_o[2]));

  // Ports write in ascending order, so the last writer to a register owns it.
  // That is the same as the highest-indexed port winning. Any register requested
  // more than once is a collision.
  function automatic rec_t refDecode(input logic [1:0] e, input logic [4:0] a0, input logic [4:0] a1);
    int   owner [32];
    int   cnt   [32];
    int   a;
    rec_t r;
    for (int i = 0; i < 32; i++) begin
      owner[i] = -1;
      cnt[i]   = 0;
    end
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? int'(a0) : int'(a1);
      if (e[p] && a != 31) begin
        cnt[a]++;
        owner[a] = p;
      end
    end
    r = '0;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? int'(a0) : int'(a1);
      if (e[p] && a != 31 && owner[a] == p) begin
        r.won[p] = 1'b1;
        r.we[a]  = 1'b1;
      end
    end
    for (int i = 0; i < 32; i++) begin
      if (cnt[i] > 1) r.col = 1'b1;
    end
    return r;
  endfunction

  task automatic modelStep();
    rec_t nr;
    logic set;
    nr = refDecode(en, addr[4:0], addr[9:5]);
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) mp[k][i] = '0;
        msticky[k] = 1'b0;
      end else begin
        set = 1'b0;
        if (flush) begin
          for (int i = 0; i < 3; i++) mp[k][i] = '0;
        end else if (!stall) begin
          for (int i = k; i > 0; i--) mp[k][i] = mp[k][i-1];
          mp[k][0] = nr;
          set = mp[k][k].col;
        end
        if (set) msticky[k] = 1'b1;
        else if (clr_sticky) msticky[k] = 1'b0;
      end
    end
  endtask

  task automatic checkVal(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, k + 1, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    rec_t e;
    for (int k = 0; k < 3; k++) begin
      e = mp[k][k];
      checkVal("model_we_vec", k, we_o[k], e.we);
      checkVal("model_port_won", k, 32'(won_o[k]), 32'(e.won));
      checkVal("model_valid_out", k, 32'(val_o[k]), 32'(e.we != 32'h0));
      checkVal("model_collision", k, 32'(col_o[k]), 32'(e.col));
      checkVal("model_sticky", k, 32'(stk_o[k]), 32'(msticky[k]));
    end
  endtask

  task automatic applyStimulus(input logic [1:0] e, input logic [4:0] a0, input logic [4:0] a1,
                               input logic st, input logic fl, input logic clr, input logic rn);
    en         = e;
    addr       = {a1, a0};
    stall      = st;
    flush      = fl;
    clr_sticky = clr;
    reset_n    = rn;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  function automatic logic [4:0] rndAddr();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 5'd31;
    if (r == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  vec_t vecs [10];
  logic [31:0] exp_d3 [7];
  logic [31:0] exp_d1 [7];

  initial begin
    vecs[0] = '{2'b01, 5'd5,  5'd0,  32'h0000_0020, 2'b01, 1'b0};
    vecs[1] = '{2'b11, 5'd7,  5'd7,  32'h0000_0080, 2'b10, 1'b1};
    vecs[2] = '{2'b01, 5'd31, 5'd0,  32'h0000_0000, 2'b00, 1'b0};
    vecs[3] = '{2'b11, 5'd31, 5'd31, 32'h0000_0000, 2'b00, 1'b0};
    vecs[4] = '{2'b10, 5'd0,  5'd3,  32'h0000_0008, 2'b10, 1'b0};
    vecs[5] = '{2'b11, 5'd2,  5'd9,  32'h0000_0204, 2'b11, 1'b0};
    vecs[6] = '{2'b00, 5'd4,  5'd4,  32'h0000_0000, 2'b00, 1'b0};
    vecs[7] = '{2'b11, 5'd31, 5'd6,  32'h0000_0040, 2'b10, 1'b0};
    vecs[8] = '{2'b11, 5'd0,  5'd31, 32'h0000_0001, 2'b01, 1'b0};
    vecs[9] = '{2'b11, 5'd30, 5'd30, 32'h4000_0000, 2'b10, 1'b1};

    exp_d3 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h4, 32'h8};
    exp_d1 = '{32'h2, 32'h4, 32'h4, 32'h4, 32'h8, 32'h0, 32'h0};

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) mp[k][i] = '0;
      msticky[k] = 1'b0;
    end

    // Reset state
    applyStimulus(2'b11, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkVal("reset_we_vec", k, we_o[k], 32'h0);
      checkVal("reset_valid", k, 32'(val_o[k]), 32'h0);
      checkVal("reset_sticky", k, 32'(stk_o[k]), 32'h0);
    end

    // Table vectors against the single-stage copy
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].a0, vecs[i].a1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkVal("table_we_vec", 0, we_o[0], vecs[i].we);
      checkVal("table_port_won", 0, 32'(won_o[0]), 32'(vecs[i].won));
      checkVal("table_collision", 0, 32'(col_o[0]), 32'(vecs[i].col));
      checkVal("table_valid", 0, 32'(val_o[0]), 32'(vecs[i].we != 32'h0));
      if (i == 1) checkVal("table_sticky_set", 0, 32'(stk_o[0]), 32'h1);
    end
    checkVal("sticky_holds", 0, 32'(stk_o[0]), 32'h1);

    // Stall sequence: writes 1,2 then a two-cycle stall, then write 3
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: applyStimulus(2'b01, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        1: applyStimulus(2'b01, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        2, 3: applyStimulus(2'b01, 5'd15, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        4: applyStimulus(2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        default: applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      endcase
      checkVal("stall_seq_d3", 2, we_o[2], exp_d3[i]);
      checkVal("stall_seq_d1", 0, we_o[0], exp_d1[i]);
    end

    // Flush together with stall while writes are in flight
    applyStimulus(2'b11, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("flush_we_vec", 1, we_o[1], 32'h0);
    checkVal("flush_collision", 1, 32'(col_o[1]), 32'h0);
    checkVal("flush_keeps_sticky", 1, 32'(stk_o[1]), 32'h1);
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("clr_sticky", 1, 32'(stk_o[1]), 32'h0);

    // Set and clear on the same edge
    applyStimulus(2'b11, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("set_beats_clr", 0, 32'(stk_o[0]), 32'h1);
    checkVal("set_beats_clr_col", 0, 32'(col_o[0]), 32'h1);

    // Reset mid-stream, then the first write appears after STAGES edges
    applyStimulus(2'b11, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkVal("midreset_we_vec", k, we_o[k], 32'h0);
      checkVal("midreset_sticky", k, 32'(stk_o[k]), 32'h0);
    end
    applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("post_reset_d1", 0, we_o[0], 32'h0000_1000);
    checkVal("post_reset_d3_e1", 2, we_o[2], 32'h0);
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("post_reset_d3_e2", 2, we_o[2], 32'h0);
    applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("post_reset_d3_e3", 2, we_o[2], 32'h0000_1000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), rndAddr(), rndAddr(),
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 10, !($urandom_range(0, 99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
